// File: rtl/fp_sp_pkg.sv
// Shared single-precision definitions for the FP unit (mul_sp_seq, div_sp).
// Field widths, special encodings, operand classes and sequencer state encodings.
package fp_sp_pkg;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_W   = 8;
  localparam int          FP_FRAC_W  = 23;
  localparam int          FP_SIG_W   = 24;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MULT,
    ST_NORM,
    ST_ROUND
  } fp_state_t;

endpackage

// File: rtl/fp_sp_classify.sv
// Combinational operand classifier; subnormals are flushed to zero.
// Emits class, sign, biased exponent and the 24-bit significand with hidden bit.
module fp_sp_classify
  import fp_sp_pkg::*;
(
  input  logic [31:0]          x,
  output fp_class_t            cls,
  output logic                 sign,
  output logic [FP_EXP_W-1:0]  expo,
  output logic [FP_SIG_W-1:0]  sig
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cls  = FP_NORMAL;
    sign = x[31];
    expo = x[30:FP_FRAC_W];
    sig  = {1'b1, x[FP_FRAC_W-1:0]};
    if (x[30:FP_FRAC_W] == '0) begin
      cls = FP_ZERO;
      sig = '0;
    end else if (x[30:FP_FRAC_W] == FP_EXP_MAX) begin
      cls = (x[FP_FRAC_W-1:0] == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/mul_sp_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier, radix-2^BPC shift-add core.
// Round-to-nearest-even, flush-to-zero on both inputs and outputs; start/done handshake.
module mul_sp_seq
  import fp_sp_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_z
);

  localparam int N_MULT = FP_SIG_W / BPC;
  localparam int SUM_W  = 2 * FP_SIG_W + BPC;

  fp_state_t state;

  logic [31:0] a_q, b_q;

  fp_class_t               cls_a, cls_b;
  logic                    sgn_a, sgn_b;
  logic [FP_EXP_W-1:0]     exp_a, exp_b;
  logic [FP_SIG_W-1:0]     sig_a, sig_b;

  fp_sp_classify u_cls_a (.x(a_q), .cls(cls_a), .sign(sgn_a), .expo(exp_a), .sig(sig_a));
  fp_sp_classify u_cls_b (.x(b_q), .cls(cls_b), .sign(sgn_b), .expo(exp_b), .sig(sig_b));

  logic                    s;
  logic signed [9:0]       e;
  logic [FP_SIG_W-1:0]     ma, mb;
  logic [2*FP_SIG_W-1:0]   acc;
  logic [4:0]              cnt;
  logic [FP_FRAC_W-1:0]    m;
  logic                    g, st;
  logic                    special;
  logic [31:0]             special_z;

  // Special-operand detection on the latched operands.
  logic        sp_hit;
  logic        s_w;
  logic [31:0] sp_z;

  always_comb begin
    s_w    = sgn_a ^ sgn_b;
    sp_hit = 1'b1;
    sp_z   = '0;
    if (cls_a == FP_NAN || cls_b == FP_NAN)
      sp_z = FP_QNAN;
    else if ((cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF))
      sp_z = FP_QNAN;
    else if (cls_a == FP_INF || cls_b == FP_INF)
      sp_z = {s_w, FP_EXP_MAX, 23'b0};
    else if (cls_a == FP_ZERO || cls_b == FP_ZERO)
      sp_z = {s_w, 31'b0};
    else
      sp_hit = 1'b0;
  end

  // One radix-2^BPC step: add the digit partial product at the top, then shift down.
  logic [2*FP_SIG_W-1:0] acc_next;
  assign acc_next = (2*FP_SIG_W)'((SUM_W'(acc)
                    + ((SUM_W'(mb) * SUM_W'(ma[BPC-1:0])) << FP_SIG_W)) >> BPC);

  logic              do_inc;
  logic [FP_SIG_W-1:0] m_inc;
  logic signed [9:0] e_rnd;
  logic [31:0]       round_z;

  always_comb begin
    do_inc  = g & (st | m[0]);
    m_inc   = {1'b0, m} + {23'b0, do_inc};
    e_rnd   = e + $signed({9'b0, m_inc[FP_SIG_W-1]});
    round_z = {s, e_rnd[7:0], m_inc[FP_FRAC_W-1:0]};
    if (e_rnd >= 10'sd255)
      round_z = {s, FP_EXP_MAX, 23'b0};
    else if (e_rnd <= 10'sd0)
      round_z = {s, 31'b0};
  end

  // NOTE: the reset is synchronous, so it lives inside the clocked branch, not in the sensitivity list.
  // NOTE: datapath registers are left unreset; only the control state and visible outputs need it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      o_done <= 1'b0;
      o_z    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            a_q   <= i_a;
            b_q   <= i_b;
            state <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          s         <= s_w;
          special   <= sp_hit;
          special_z <= sp_z;
          e         <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(10'(FP_BIAS));
          ma        <= sig_a;
          mb        <= sig_b;
          acc       <= '0;
          cnt       <= '0;
          // Specials take the ROUND slot so their result lands two cycles after accept.
          state     <= sp_hit ? ST_ROUND : ST_MULT;
        end
        ST_MULT: begin
          acc <= acc_next;
          ma  <= ma >> BPC;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(N_MULT - 1))
            state <= ST_NORM;
        end
        ST_NORM: begin
          if (acc[47]) begin
            m  <= acc[46:24];
            g  <= acc[23];
            st <= |acc[22:0];
            e  <= e + 10'sd1;
          end else begin
            m  <= acc[45:23];
            g  <= acc[22];
            st <= |acc[21:0];
          end
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          o_z    <= special ? special_z : round_z;
          o_done <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_sp_seq.sv
// Scoreboard bench for mul_sp_seq at BPC=1 and BPC=4.
// Expected results and latencies are queued at issue and checked when o_done fires.
module tb_mul_sp_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [31:0] i_a, i_b;
  int          sel;
  int          nlat;
  int          cyc = 0;

  logic        start1, start4;
  logic        busy1, busy4, done1, done4;
  logic [31:0] z1, z4;
  logic        busy_s, done_s, done_o;
  logic [31:0] z_s;

  assign start1 = start && (sel == 0);
  assign start4 = start && (sel != 0);

  always_comb begin
    busy_s = (sel != 0) ? busy4 : busy1;
    done_s = (sel != 0) ? done4 : done1;
    done_o = (sel != 0) ? done1 : done4;
    z_s    = (sel != 0) ? z4    : z1;
  end

  mul_sp_seq #(.BPC(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_start(start1), .i_a(i_a), .i_b(i_b),
    .o_busy(busy1), .o_done(done1), .o_z(z1)
  );

  mul_sp_seq #(.BPC(4)) u_dut4 (
    .clk(clk), .reset(reset), .i_start(start4), .i_a(i_a), .i_b(i_b),
    .o_busy(busy4), .o_done(done4), .o_z(z4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] z;
    int          acc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  // Reference: exact 48-bit product, then RNE to 24 bits with FTZ on both ends.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, za, zb, ia, ib, na, nb;
    logic [47:0] p;
    logic [23:0] mm;
    int          e;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (na || nb) return 32'h7FC0_0000;
    if ((ia && zb) || (za && ib)) return 32'h7FC0_0000;
    if (ia || ib) return {s, 8'hFF, 23'b0};
    if (za || zb) return {s, 31'b0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) e++;
    else p = p << 1;
    mm = {1'b0, p[46:24]} + 24'(p[23] && ((p[22:0] != 0) || p[24]));
    if (mm[23]) begin
      e++;
      mm = '0;
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0) return {s, 31'b0};
    return {s, e[7:0], mm[22:0]};
  endfunction

  always @(negedge clk) begin
    if (done_s) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_z"}, z_s, e.z);
        check({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    if (done_o) check("idle_dut_done", 32'd1, 32'd0);
  end

  // Called at a falling edge; the next rising edge is the accepting one.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                       input string tag, input bit push);
    exp_t e;
    i_a   = a;
    i_b   = b;
    start = 1'b1;
    if (push) begin
      e.z   = z;
      e.acc = cyc + 1;
      e.lat = is_special(a, b) ? 2 : nlat;
      e.tag = tag;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  logic [31:0] dir_a [16] = '{
    32'h4040_0000, 32'hBFC0_0000, 32'h7F80_0000, 32'hFF80_0000,
    32'h7FC0_0001, 32'h7F00_0000, 32'h0080_0000, 32'h8000_0000,
    32'h3F80_0001, 32'h3FFF_FFFF, 32'h3F80_0001, 32'h3F80_0003,
    32'h7F7F_FFFF, 32'h0040_0000, 32'h0000_0000, 32'h3F80_0000
  };
  logic [31:0] dir_b [16] = '{
    32'h4020_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4000_0000,
    32'h3F80_0000, 32'h4000_0000, 32'h0080_0000, 32'h3F80_0000,
    32'h3F80_0001, 32'h3FFF_FFFF, 32'h3FC0_0000, 32'h3FC0_0000,
    32'h3F80_0001, 32'h4000_0000, 32'hFF80_0000, 32'h7F80_0001
  };
  logic [31:0] dir_z [16] = '{
    32'h40F0_0000, 32'hBFC0_0000, 32'h7FC0_0000, 32'hFF80_0000,
    32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000,
    32'h3F80_0002, 32'h407F_FFFE, 32'h3FC0_0002, 32'h3FC0_0004,
    32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000
  };

  task automatic run_suite(input int s);
    int n;
    sel  = s;
    nlat = ((s != 0) ? 6 : 24) + 3;

    for (int i = 0; i < 16; i++) begin
      issue(dir_a[i], dir_b[i], dir_z[i], $sformatf("dir%0d_bpc%0d", i, s), 1'b1);
      drain(60);
    end

    // Second start lands in the o_done cycle of the first.
    issue(32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, "b2b_first", 1'b1);
    n = 0;
    while (!done_s && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 32'(done_s), 32'd1);
    issue(32'hBFC0_0000, 32'h3F80_0000, 32'hBFC0_0000, "b2b_second", 1'b1);
    drain(60);

    // A start while busy must be dropped.
    issue(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, "busy_first", 1'b1);
    repeat (3) @(negedge clk);
    check("busy_mid_op", 32'(busy_s), 32'd1);
    issue(32'h40A0_0000, 32'h40A0_0000, 32'h41C8_0000, "busy_ignored", 1'b0);
    drain(60);
    repeat (nlat + 5) @(negedge clk);

    // Reset in the middle of MULT discards the operation.
    issue(32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, "aborted", 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy_s), 32'd0);
    check("abort_z", z_s, 32'd0);
    check("abort_done", 32'(done_s), 32'd0);
    reset = 1'b1;
    repeat (nlat + 5) @(negedge clk);
    issue(32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, "after_abort", 1'b1);
    drain(60);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      if (i < 10) begin
        ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      issue(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d_bpc%0d", i, s), 1'b1);
      drain(60);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    i_a   = '0;
    i_b   = '0;
    sel   = 0;
    nlat  = 27;
    repeat (3) @(negedge clk);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_z1", z1, 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_z4", z4, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_suite(0);
    run_suite(1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
